// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the cache miss/array logic, the pipelined memory and the fill controller.
// master: the fill controller's view. slave: the cache/memory side driving misses and data.
interface cache_fill_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned WAYS   = 2
);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [WAY_W-1:0]  victim_way;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              mem_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [WORDS-1:0]  word_sel;
    logic [WAYS-1:0]   fill_way;
    logic              write_tag_array;
    logic              fill_done;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  victim_way,
        input  memory_data_valid,
        output fsm_busy,
        output mem_req,
        output memory_address,
        output write_data_array,
        output word_sel,
        output fill_way,
        output write_tag_array,
        output fill_done
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output victim_way,
        output memory_data_valid,
        input  fsm_busy,
        input  mem_req,
        input  memory_address,
        input  write_data_array,
        input  word_sel,
        input  fill_way,
        input  write_tag_array,
        input  fill_done
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache-line fill controller. On a miss it latches the line base and victim way, issues WORDS
// word reads on consecutive cycles and writes each returning word into the victim way. Issue and
// receive progress are tracked by separate counters so any memory latency >= 1 works; the tag is
// written one cycle after the last word lands.
// Build macro CRIT_WORD_FIRST_EN: start issue and receive at the missed word and wrap around.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORDS  = 8,
    parameter int unsigned WAYS   = 2
) (
    input logic               clk,
    input logic               rst,
    cache_fill_ctrl_if.master io_bus
);
    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned CNT_W  = OFF_W + 1;
    localparam int unsigned BASE_W = ADDR_W - OFF_W - 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [BASE_W-1:0] r_line_base;
    logic [WAY_W-1:0]  r_way;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_recv_cnt;
    logic [OFF_W-1:0]  w_start_off;
    logic [OFF_W-1:0]  w_issue_off;
    logic [OFF_W-1:0]  w_recv_off;
    logic              w_start;
    logic              w_issue;
    logic              w_recv;
    logic              w_recv_last;
    logic              w_unused_addr;

    assign w_start     = (r_state == StIdle) && io_bus.miss_detected;
    assign w_issue     = (r_state == StFill) && (r_issue_cnt < CNT_W'(WORDS));
    assign w_recv      = (r_state == StFill) && io_bus.memory_data_valid;
    assign w_recv_last = w_recv && (r_recv_cnt == CNT_W'(WORDS - 1));

    // Byte offset is never used; word offset only matters with critical-word-first.
    assign w_unused_addr = ^io_bus.miss_address[OFF_W:0];

`ifdef CRIT_WORD_FIRST_EN
    logic [OFF_W-1:0] r_start_off;

    // Latch the missed word offset as the starting point for both issue and receive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_off <= '0;
        end else if (w_start) begin
            r_start_off <= io_bus.miss_address[OFF_W:1];
        end
    end

    assign w_start_off = r_start_off;
`else
    assign w_start_off = '0;
`endif

    // Offsets wrap naturally modulo WORDS because they are OFF_W bits wide.
    assign w_issue_off = w_start_off + r_issue_cnt[OFF_W-1:0];
    assign w_recv_off  = w_start_off + r_recv_cnt[OFF_W-1:0];

    // State register, latched miss context and the independent issue/receive counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_line_base <= '0;
            r_way       <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_line_base <= io_bus.miss_address[ADDR_W-1:OFF_W+1];
                r_way       <= io_bus.victim_way;
            end
            if (w_start) begin
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            end
            if (w_start) begin
                r_recv_cnt <= '0;
            end else if (w_recv) begin
                r_recv_cnt <= r_recv_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state and all outputs; everything is zero in IDLE except the early busy.
    always_comb begin
        w_state_next            = r_state;
        io_bus.fsm_busy         = 1'b0;
        io_bus.mem_req          = 1'b0;
        io_bus.memory_address   = '0;
        io_bus.write_data_array = 1'b0;
        io_bus.word_sel         = '0;
        io_bus.fill_way         = '0;
        io_bus.write_tag_array  = 1'b0;
        io_bus.fill_done        = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Stall the pipeline in the miss cycle itself, before the FSM moves.
                io_bus.fsm_busy = io_bus.miss_detected;
                if (io_bus.miss_detected) begin
                    w_state_next = StFill;
                end
            end
            StFill: begin
                io_bus.fsm_busy         = 1'b1;
                io_bus.fill_way         = WAYS'(1) << r_way;
                io_bus.mem_req          = w_issue;
                io_bus.write_data_array = w_recv;
                if (w_issue) begin
                    io_bus.memory_address = {r_line_base, w_issue_off, 1'b0};
                end
                if (w_recv) begin
                    io_bus.word_sel = WORDS'(1) << w_recv_off;
                end
                if (w_recv_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                io_bus.fsm_busy        = 1'b1;
                io_bus.fill_way        = WAYS'(1) << r_way;
                io_bus.write_tag_array = 1'b1;
                io_bus.fill_done       = 1'b1;
                w_state_next           = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: table of directed fills, hand sequences for reset/back-to-back/
// stray-valid corners, randomized fills against a transaction-level model, plus a WORDS=4/WAYS=4
// instance. Honours CRIT_WORD_FIRST_EN when the build defines it.
module tb_cache_fill_ctrl;
    localparam int unsigned WORDS = 8;

`ifdef CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic        way;
        int          lat;
        logic [31:0] mask;
        logic [15:0] exp_first_addr;
        logic [15:0] exp_last_addr;
        logic [7:0]  exp_first_sel;
        logic [7:0]  exp_last_sel;
        logic [1:0]  exp_way;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [15:0] obs_req[$];
    int          obs_req_cyc[$];
    logic [7:0]  obs_sel[$];
    int          last_wr_cyc;
    int          done_cyc;
    int          n_done;
    int          n_tag;
    logic [1:0]  obs_way;

    cache_fill_ctrl_if #(.ADDR_W(16), .WORDS(8), .WAYS(2)) bus8 ();
    cache_fill_ctrl_if #(.ADDR_W(16), .WORDS(4), .WAYS(4)) bus4 ();

    cache_fill_ctrl #(.ADDR_W(16), .WORDS(8), .WAYS(2)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus8)
    );

    cache_fill_ctrl #(.ADDR_W(16), .WORDS(4), .WAYS(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: words are fetched starting at the start offset and wrap modulo WORDS.
    function automatic int start_off(input logic [15:0] a);
        return CWF ? int'(a[3:1]) : 0;
    endfunction

    function automatic logic [15:0] model_addr(input logic [15:0] a, input int k);
        return (a & 16'hFFF0) | 16'(((start_off(a) + k) % 8) * 2);
    endfunction

    function automatic logic [7:0] model_sel(input logic [15:0] a, input int k);
        return 8'(1 << ((start_off(a) + k) % 8));
    endfunction

    // One fill on the 8-word instance; memory returns each request no earlier than lat cycles
    // later, in order, when the gap source allows. Records what the DUT did.
    task automatic run_fill(input logic [15:0] addr, input logic way, input int lat,
                            input logic [31:0] mask, input bit rnd, input bit hold);
        int ready_q[$];
        int given;
        bit ok;
        obs_req.delete();
        obs_req_cyc.delete();
        obs_sel.delete();
        last_wr_cyc = -1;
        done_cyc    = -1;
        n_done      = 0;
        n_tag       = 0;
        obs_way     = '0;
        given       = 0;
        bus8.miss_detected     = 1'b1;
        bus8.miss_address      = addr;
        bus8.victim_way        = way;
        bus8.memory_data_valid = 1'b0;
        @(negedge clk);
        check("busy_on_miss", bus8.fsm_busy, 1);
        check("no_req_on_miss", bus8.mem_req, 0);
        @(posedge clk); #1;
        bus8.miss_detected = hold;
        for (int cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
            bus8.miss_address = 16'($urandom);
            bus8.victim_way   = 1'($urandom);
            if (rnd && !hold) bus8.miss_detected = ($urandom_range(0, 3) == 0);
            ok = rnd ? ($urandom_range(0, 2) != 0) : mask[cyc % 32];
            bus8.memory_data_valid = 1'b0;
            if (given == WORDS) begin
                // Lands in the DONE cycle and must be ignored.
                bus8.memory_data_valid = 1'b1;
            end else if (ready_q.size() > 0 && ok && ready_q[0] <= cyc) begin
                bus8.memory_data_valid = 1'b1;
                void'(ready_q.pop_front());
                given++;
            end
            @(negedge clk);
            if (bus8.mem_req) begin
                obs_req.push_back(bus8.memory_address);
                obs_req_cyc.push_back(cyc);
                ready_q.push_back(cyc + lat);
            end
            if (bus8.write_data_array) begin
                obs_sel.push_back(bus8.word_sel);
                last_wr_cyc = cyc;
            end
            if (cyc == 1) obs_way = bus8.fill_way;
            check("busy_in_fill", bus8.fsm_busy, 1);
            check("tag_with_done", bus8.write_tag_array, bus8.fill_done);
            if (bus8.write_tag_array) n_tag++;
            if (bus8.fill_done) begin
                n_done++;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        check("fill_done_seen", n_done, 1);
        bus8.memory_data_valid = 1'b0;
        if (!hold) begin
            bus8.miss_detected = 1'b0;
            @(negedge clk);
            check("idle_busy", bus8.fsm_busy, 0);
            check("idle_way", bus8.fill_way, 0);
            check("idle_req", bus8.mem_req, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_fill(input logic [15:0] addr, input logic way);
        check("req_count", obs_req.size(), WORDS);
        check("wr_count", obs_sel.size(), WORDS);
        check("tag_count", n_tag, 1);
        check("done_after_last_valid", done_cyc, last_wr_cyc + 1);
        check("fill_way", obs_way, 2'b01 << way);
        for (int k = 0; k < obs_req.size() && k < WORDS; k++) begin
            check($sformatf("req_addr[%0d]", k), obs_req[k], model_addr(addr, k));
            check($sformatf("req_cycle[%0d]", k), obs_req_cyc[k], k + 1);
        end
        for (int k = 0; k < obs_sel.size() && k < WORDS; k++) begin
            check($sformatf("word_sel[%0d]", k), obs_sel[k], model_sel(addr, k));
        end
    endtask

    initial begin
        vec_t vecs[4];
        logic [3:0][15:0] exp4_addr;
        logic [3:0][3:0]  exp4_sel;
        logic [15:0] a;
        logic        w;
        int pend;
        int wr;
        int nreq;
        int nwr;
        bit seen;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{16'h1234, 1'b1, 4, 32'hFFFF_FFFF,
                    CWF ? 16'h1234 : 16'h1230, CWF ? 16'h1232 : 16'h123E,
                    CWF ? 8'h04 : 8'h01, CWF ? 8'h02 : 8'h80, 2'b10};
        vecs[1] = '{16'h1236, 1'b0, 1, 32'h6D6D_6D6D,
                    CWF ? 16'h1236 : 16'h1230, CWF ? 16'h1234 : 16'h123E,
                    CWF ? 8'h08 : 8'h01, CWF ? 8'h04 : 8'h80, 2'b01};
        vecs[2] = '{16'hFFFF, 1'b1, 2, 32'h5555_5555,
                    CWF ? 16'hFFFE : 16'hFFF0, CWF ? 16'hFFFC : 16'hFFFE,
                    CWF ? 8'h80 : 8'h01, CWF ? 8'h40 : 8'h80, 2'b10};
        vecs[3] = '{16'h0008, 1'b0, 7, 32'hF0F0_F0F0,
                    CWF ? 16'h0008 : 16'h0000, CWF ? 16'h0006 : 16'h000E,
                    CWF ? 8'h10 : 8'h01, CWF ? 8'h08 : 8'h80, 2'b01};
        exp4_addr = CWF ? {16'hABCA, 16'hABC8, 16'hABCE, 16'hABCC}
                        : {16'hABCE, 16'hABCC, 16'hABCA, 16'hABC8};
        exp4_sel  = CWF ? {4'h2, 4'h1, 4'h8, 4'h4} : {4'h8, 4'h4, 4'h2, 4'h1};

        rst = 1'b1;
        bus8.miss_detected = 1'b0;
        bus8.miss_address = '0;
        bus8.victim_way = '0;
        bus8.memory_data_valid = 1'b0;
        bus4.miss_detected = 1'b0;
        bus4.miss_address = '0;
        bus4.victim_way = '0;
        bus4.memory_data_valid = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", bus8.fsm_busy, 0);
        check("rst_req", bus8.mem_req, 0);
        check("rst_addr", bus8.memory_address, 0);
        check("rst_wr", {bus8.write_data_array, bus8.word_sel}, 0);
        check("rst_way", bus8.fill_way, 0);
        check("rst_tag_done", {bus8.write_tag_array, bus8.fill_done}, 0);
        check("rst_b4_busy", bus4.fsm_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Stray valids in IDLE
        bus8.memory_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_stray_wr", bus8.write_data_array, 0);
            check("idle_stray_busy", bus8.fsm_busy, 0);
            @(posedge clk); #1;
        end
        bus8.memory_data_valid = 1'b0;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_fill(vecs[i].addr, vecs[i].way, vecs[i].lat, vecs[i].mask, 1'b0, 1'b0);
            check_fill(vecs[i].addr, vecs[i].way);
            check($sformatf("v%0d_first_addr", i),
                  obs_req.size() > 0 ? obs_req[0] : 16'h0, vecs[i].exp_first_addr);
            check($sformatf("v%0d_last_addr", i),
                  obs_req.size() > 0 ? obs_req[obs_req.size()-1] : 16'h0, vecs[i].exp_last_addr);
            check($sformatf("v%0d_first_sel", i),
                  obs_sel.size() > 0 ? obs_sel[0] : 8'h0, vecs[i].exp_first_sel);
            check($sformatf("v%0d_last_sel", i),
                  obs_sel.size() > 0 ? obs_sel[obs_sel.size()-1] : 8'h0, vecs[i].exp_last_sel);
            check($sformatf("v%0d_way", i), obs_way, vecs[i].exp_way);
        end

        // Asynchronous reset after three received words
        bus8.miss_detected = 1'b1;
        bus8.miss_address = 16'h1234;
        bus8.victim_way = 1'b1;
        @(posedge clk); #1;
        bus8.miss_detected = 1'b0;
        pend = 0;
        wr = 0;
        for (int cyc = 1; cyc < 40 && wr < 3; cyc++) begin
            bus8.memory_data_valid = (pend > 0);
            if (pend > 0) pend--;
            @(negedge clk);
            if (bus8.mem_req) pend++;
            if (bus8.write_data_array) wr++;
            if (wr < 3) begin
                @(posedge clk); #1;
            end
        end
        check("pre_reset_writes", wr, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", bus8.fsm_busy, 0);
        check("arst_req", bus8.mem_req, 0);
        check("arst_addr", bus8.memory_address, 0);
        check("arst_wr", {bus8.write_data_array, bus8.word_sel}, 0);
        check("arst_way", bus8.fill_way, 0);
        check("arst_tag_done", {bus8.write_tag_array, bus8.fill_done}, 0);
        bus8.memory_data_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("arst_hold_tag_done", {bus8.write_tag_array, bus8.fill_done}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_fill(16'h1234, 1'b1, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check_fill(16'h1234, 1'b1);
        check("restart_first_sel", obs_sel.size() > 0 ? obs_sel[0] : 8'h0,
              CWF ? 8'h04 : 8'h01);

        // Miss held high: second fill starts the cycle after DONE with the new address
        run_fill(16'h2468, 1'b0, 3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check_fill(16'h2468, 1'b0);
        run_fill(16'h1357, 1'b1, 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check_fill(16'h1357, 1'b1);

        // Randomized fills, random latency, gaps and ignored miss pulses
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom);
            w = 1'($urandom);
            run_fill(a, w, int'($urandom_range(1, 6)), 32'hFFFF_FFFF, 1'b1, 1'b0);
            check_fill(a, w);
        end

        // WORDS=4, WAYS=4 instance
        bus4.miss_detected = 1'b1;
        bus4.miss_address = 16'hABCD;
        bus4.victim_way = 2'd3;
        @(negedge clk);
        check("b4_busy_on_miss", bus4.fsm_busy, 1);
        @(posedge clk); #1;
        bus4.miss_detected = 1'b0;
        bus4.miss_address = 16'h0000;
        bus4.victim_way = 2'd0;
        pend = 0;
        nreq = 0;
        nwr = 0;
        seen = 1'b0;
        for (int cyc = 1; cyc < 40 && !seen; cyc++) begin
            bus4.memory_data_valid = (pend > 0);
            if (pend > 0) pend--;
            @(negedge clk);
            if (bus4.mem_req) begin
                if (nreq < 4) check($sformatf("b4_addr[%0d]", nreq), bus4.memory_address,
                                    exp4_addr[nreq]);
                nreq++;
                pend++;
            end
            if (bus4.write_data_array) begin
                if (nwr < 4) check($sformatf("b4_sel[%0d]", nwr), bus4.word_sel, exp4_sel[nwr]);
                nwr++;
            end
            check("b4_fill_way", bus4.fill_way, 4'b1000);
            if (bus4.fill_done) begin
                seen = 1'b1;
                check("b4_tag", bus4.write_tag_array, 1);
            end
            @(posedge clk); #1;
        end
        bus4.memory_data_valid = 1'b0;
        check("b4_req_count", nreq, 4);
        check("b4_wr_count", nwr, 4);
        check("b4_done_seen", seen, 1);
        @(negedge clk);
        check("b4_idle_busy", bus4.fsm_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Parametrised cache-line fill controller for the L1 instruction/data caches. On a tag-match miss it latches the miss address and victim way, issues one word read per cycle to the pipelined memory, and steers returning words into the selected way's data array. It writes the tag array when the final word lands. It replaces the fixed 8-word, 2-way fill FSM and decouples the request issue count from the data receive count.

Parameters:
ADDR_W, 16, byte-address width
WORDS, 8, 16-bit words per cache line; power of 2, 2..64
WAYS, 2, associativity; power of 2, 1..8

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
miss_detected  in  1  high when tag-match logic reports a miss
miss_address  in  ADDR_W  byte address that missed
victim_way  in  log2(WAYS) (min 1)  way to replace, from the LRU logic
memory_data_valid  in  1  valid data on the memory return bus
fsm_busy  out  1  pipeline stall
mem_req  out  1  read request to memory, one word per cycle
memory_address  out  ADDR_W  word-aligned request address
write_data_array  out  1  data-array write enable
word_sel  out  WORDS  one-hot word enable for the current data write
fill_way  out  WAYS  one-hot way enable for data and tag writes
write_tag_array  out  1  tag-array write enable, one cycle
fill_done  out  1  one-cycle pulse when the fill completes

Behaviour:
- OFF_W = log2(WORDS). Bit 0 of every address is the byte offset.
- Word offset is addr[OFF_W:1]. The line base is addr[ADDR_W-1:OFF_W+1].
- State machine states are IDLE, FILL and DONE. Reset enters IDLE.
- Reset values: all outputs 0; issue_cnt, recv_cnt and latched registers 0.
- IDLE:
  - When miss_detected=1, latch miss_address and victim_way, clear both counters, and go to FILL.
  - fsm_busy is asserted combinationally in the same cycle as miss_detected.
- FILL, issue side:
  - mem_req=1 while issued < WORDS.
  - memory_address = {line base, issue offset, 1'b0}.
  - The issue offset advances by 1 each cycle with mem_req=1.
  - Exactly WORDS requests are issued on consecutive cycles, starting the cycle after entry.
- FILL, receive side:
  - Each memory_data_valid=1 causes write_data_array=1 in the same cycle.
  - word_sel = one-hot of the receive offset.
  - The receive offset advances by 1.
- Issue and receive progress independently. Data may arrive while requests are still being issued, with any memory latency ≥1.
- FILL -> DONE: on the cycle the WORDS-th valid is accepted.
- DONE (one cycle): write_tag_array=1 and fill_done=1, then go to IDLE.
- fill_way = one-hot(latched victim_way) in FILL and DONE, 0 in IDLE.
- fsm_busy=1 in FILL and DONE. fsm_busy drops in the cycle after DONE unless a new miss_detected arrives.
- Ignored inputs:
  - miss_detected in FILL or DONE.
  - memory_data_valid in IDLE or DONE.
  - Changes to miss_address or victim_way after the latch.
- Counters use OFF_W+1 bits so the terminal count WORDS is representable.
- Offsets wrap modulo WORDS.
- Asynchronous reset mid-fill returns to IDLE immediately. It causes no tag write and no fill_done.
- Back-to-back miss: miss_detected in the cycle after DONE starts a new fill with no idle gap.

Optional Feature:
CRIT_WORD_FIRST_EN
- Defined: both the issue and receive offsets start at the latched miss word offset and wrap modulo WORDS. The requested word is therefore returned first.
- Undefined: both offsets start at 0. The latched miss word offset is unused.

Test Plan:
1. WORDS=8, WAYS=2, memory latency 4. miss_address=0x1234, victim_way=1 ->
   - mem_req for 8 cycles with addresses 0x1230, 0x1232 … 0x123E.
   - 8 data writes with word_sel 0x01 → 0x80 and fill_way=2'b10.
   - Then write_tag_array and fill_done high for one cycle.
   - fsm_busy is high from the miss cycle through DONE.
2. CRIT_WORD_FIRST_EN defined, miss_address=0x1236 -> request order 0x1236, 0x1238 … 0x123E, 0x1230, 0x1232, 0x1234; first word_sel=0x08; last word_sel=0x04.
3. Gapped valids: valid pattern 1,0,1,1,0,… ->
   - Exactly 8 data writes, in order.
   - DONE follows the 8th valid only.
   - Stray valids in IDLE cause no write.
4. Assert rst asynchronously after 3 received words -> all outputs 0 immediately, state IDLE, no write_tag_array; the next miss restarts at word 0.
5. Hold miss_detected=1 continuously -> the second fill starts the cycle after DONE using the newly latched address. miss_detected pulses during FILL are ignored.
6. WORDS=4, WAYS=4, victim_way=3, miss_address=0xABCD -> addresses 0xABC8, 0xABCA, 0xABCC, 0xABCE; fill_way=4'b1000.
